// File: rtl/sp_pkg.sv
// Shared types and helpers for the shortest-path relaxation engine.
// Combinational helpers only; no state.
package sp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RELAX = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Minimum of 1 so single-entry ranges still get a usable index bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic logic [31:0] dist_inf(input int w);
        return 32'hFFFF_FFFF >> (32 - w);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[31:0];
    endfunction

endpackage

// File: rtl/sp_edge_store.sv
// Edge register file: synchronous write while loading, combinational indexed read while relaxing.
// Read data valid in the same cycle as the index; no flow control.
module sp_edge_store #(
    parameter int MAX_EDGES = 16,
    parameter int NW        = 3,
    parameter int W_WIDTH   = 8,
    parameter int AW        = 4
) (
    input  logic               CLK,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_idx,
    input  logic [NW-1:0]      i_wr_src,
    input  logic [NW-1:0]      i_wr_dst,
    input  logic [W_WIDTH-1:0] i_wr_w,
    input  logic [AW-1:0]      i_rd_idx,
    output logic [NW-1:0]      o_rd_src,
    output logic [NW-1:0]      o_rd_dst,
    output logic [W_WIDTH-1:0] o_rd_w
);

    typedef struct packed {
        logic [NW-1:0]      src;
        logic [NW-1:0]      dst;
        logic [W_WIDTH-1:0] wt;
    } edge_t;

    edge_t r_mem [MAX_EDGES];

    always_ff @(posedge CLK) begin
        if (i_wr_en) r_mem[i_wr_idx] <= '{src: i_wr_src, dst: i_wr_dst, wt: i_wr_w};
    end

    assign o_rd_src = r_mem[i_rd_idx].src;
    assign o_rd_dst = r_mem[i_rd_idx].dst;
    assign o_rd_w   = r_mem[i_rd_idx].wt;

endmodule

// File: rtl/sp_relax_engine.sv
// Single-source shortest path: load edge burst, Bellman-Ford relax with early exit, stream distances.
// Latency passes*E+1 cycles from burst end to first result; input beats outside IDLE/LOAD are ignored.
module sp_relax_engine
    import sp_pkg::*;
#(
    parameter  int NODES     = 8,
    parameter  int MAX_EDGES = 16,
    parameter  int W_WIDTH   = 8,
    parameter  int D_WIDTH   = 16,
    localparam int NW        = clog2(NODES)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               IN_VALID,
    input  logic [NW-1:0]      IN_START,
    input  logic [NW-1:0]      IN_SRC,
    input  logic [NW-1:0]      IN_DST,
    input  logic [W_WIDTH-1:0] IN_W,
    output logic               BUSY,
    output logic               OVF,
    output logic               OUT_VALID,
    output logic [NW-1:0]      OUT_NODE,
    output logic [D_WIDTH-1:0] OUT_DIST,
    output logic               OUT_REACH
);

    localparam int EW = clog2(MAX_EDGES + 1);
    localparam int AW = clog2(MAX_EDGES);
    localparam logic [D_WIDTH-1:0] INF = D_WIDTH'(dist_inf(D_WIDTH));
    localparam logic [31:0]        LIM = dist_inf(D_WIDTH) - 32'd1;

    state_t             r_state, w_state_nxt;
    logic [NW-1:0]      r_start;
    logic [EW-1:0]      r_e;
    logic [AW-1:0]      r_idx;
    logic [NW-1:0]      r_pass;
    logic               r_chg;
    logic [D_WIDTH-1:0] r_dist [NODES];

    logic               w_ids_ok, w_first_ok, w_room, w_wr;
    logic [NW-1:0]      w_src, w_dst, w_nxt_node;
    logic [W_WIDTH-1:0] w_w;
    logic [D_WIDTH-1:0] w_ds, w_dd, w_cand, w_fwd0;
    logic               w_upd, w_pass_end, w_done, w_load_end, w_first_emit, w_last_beat;

    assign w_ids_ok   = (int'(IN_SRC) < NODES) && (int'(IN_DST) < NODES);
    assign w_first_ok = w_ids_ok && (int'(IN_START) < NODES);
    assign w_room     = int'(r_e) < MAX_EDGES;
    assign w_wr       = IN_VALID && (((r_state == ST_IDLE) && w_first_ok) ||
                                     ((r_state == ST_LOAD) && w_ids_ok && w_room));

    sp_edge_store #(
        .MAX_EDGES(MAX_EDGES), .NW(NW), .W_WIDTH(W_WIDTH), .AW(AW)
    ) u_store (
        .CLK      (CLK),
        .i_wr_en  (w_wr),
        .i_wr_idx ((r_state == ST_IDLE) ? '0 : r_e[AW-1:0]),
        .i_wr_src (IN_SRC),
        .i_wr_dst (IN_DST),
        .i_wr_w   (IN_W),
        .i_rd_idx (r_idx),
        .o_rd_src (w_src),
        .o_rd_dst (w_dst),
        .o_rd_w   (w_w)
    );

    assign w_ds       = r_dist[w_src];
    assign w_dd       = r_dist[w_dst];
    assign w_cand     = D_WIDTH'(sat_add(32'(w_ds), 32'(w_w), LIM));
    assign w_upd      = (r_state == ST_RELAX) && (w_ds != INF) && (w_cand < w_dd);
    assign w_pass_end = (r_state == ST_RELAX) && (EW'(r_idx) == r_e - EW'(1));
    assign w_done     = w_pass_end && (!(r_chg || w_upd) || (r_pass == NW'(NODES - 1)));
    assign w_load_end = (r_state == ST_LOAD) && !IN_VALID;
    assign w_first_emit = w_done || (w_load_end && (r_e == '0));
    assign w_last_beat  = (r_state == ST_OUT) && (OUT_NODE == NW'(NODES - 1));
    assign w_nxt_node   = OUT_NODE + NW'(1);
    // Node 0 may be written by the final relax edge in the same cycle its beat is registered.
    assign w_fwd0 = (w_upd && (w_dst == '0)) ? w_cand : r_dist[0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (IN_VALID) w_state_nxt = ST_LOAD;
            ST_LOAD:  if (!IN_VALID) w_state_nxt = (r_e == '0) ? ST_OUT : ST_RELAX;
            ST_RELAX: if (w_done) w_state_nxt = ST_OUT;
            ST_OUT:   if (w_last_beat) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_start   <= '0;
            r_e       <= '0;
            r_idx     <= '0;
            r_pass    <= '0;
            r_chg     <= 1'b0;
            BUSY      <= 1'b0;
            OVF       <= 1'b0;
            OUT_VALID <= 1'b0;
            OUT_NODE  <= '0;
            OUT_DIST  <= '0;
            OUT_REACH <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && IN_VALID) begin
                r_start <= IN_START;
                r_e     <= w_first_ok ? EW'(1) : '0;
                OVF     <= !w_first_ok;
                BUSY    <= 1'b1;
            end
            if ((r_state == ST_LOAD) && IN_VALID) begin
                if (w_ids_ok && w_room) r_e <= r_e + EW'(1);
                else                    OVF <= 1'b1;
            end
            if (w_load_end) begin
                r_idx  <= '0;
                r_pass <= NW'(1);
                r_chg  <= 1'b0;
            end
            if (r_state == ST_RELAX) begin
                if (w_pass_end) begin
                    r_idx  <= '0;
                    r_pass <= r_pass + NW'(1);
                    r_chg  <= 1'b0;
                end else begin
                    r_idx  <= r_idx + AW'(1);
                    r_chg  <= r_chg || w_upd;
                end
            end
            if (w_first_emit) begin
                OUT_VALID <= 1'b1;
                OUT_NODE  <= '0;
                OUT_DIST  <= w_fwd0;
                OUT_REACH <= (w_fwd0 != INF);
            end else if (r_state == ST_OUT) begin
                if (w_last_beat) begin
                    OUT_VALID <= 1'b0;
                    OUT_NODE  <= '0;
                    OUT_DIST  <= '0;
                    OUT_REACH <= 1'b0;
                    BUSY      <= 1'b0;
                end else begin
                    OUT_NODE  <= w_nxt_node;
                    OUT_DIST  <= r_dist[w_nxt_node];
                    OUT_REACH <= (r_dist[w_nxt_node] != INF);
                end
            end
        end
    end

    // Distance array is fully reinitialised on every first beat, so it needs no reset.
    always_ff @(posedge CLK) begin
        if ((r_state == ST_IDLE) && IN_VALID) begin
            for (int n = 0; n < NODES; n++)
                r_dist[n] <= (NW'(n) == IN_START) ? '0 : INF;
        end else if (w_upd) begin
            r_dist[w_dst] <= w_cand;
        end
    end

endmodule

// File: tb/tb_sp_relax_engine.sv
// Directed bench for sp_relax_engine; D_WIDTH=10 so saturation (1022) is reachable with 8 nodes.
module tb_sp_relax_engine;

    localparam int NODES = 8;
    localparam int DW    = 10;
    localparam int INF   = 1023;

    logic           CLK = 1'b0;
    logic           RESET;
    logic           IN_VALID;
    logic [2:0]     IN_START, IN_SRC, IN_DST;
    logic [7:0]     IN_W;
    logic           BUSY, OVF, OUT_VALID, OUT_REACH;
    logic [2:0]     OUT_NODE;
    logic [DW-1:0]  OUT_DIST;

    int n_pass = 0;
    int n_chk  = 0;
    int exp_d [NODES];
    logic [2:0] q_src [$];
    logic [2:0] q_dst [$];
    logic [7:0] q_w   [$];

    sp_relax_engine #(
        .NODES(NODES), .MAX_EDGES(16), .W_WIDTH(8), .D_WIDTH(DW)
    ) dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_START(IN_START),
        .IN_SRC(IN_SRC), .IN_DST(IN_DST), .IN_W(IN_W), .BUSY(BUSY), .OVF(OVF),
        .OUT_VALID(OUT_VALID), .OUT_NODE(OUT_NODE), .OUT_DIST(OUT_DIST), .OUT_REACH(OUT_REACH)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic add(input logic [2:0] s, input logic [2:0] d, input logic [7:0] w);
        q_src.push_back(s);
        q_dst.push_back(d);
        q_w.push_back(w);
    endtask

    task automatic send(input logic [2:0] start);
        for (int i = 0; i < q_src.size(); i++) begin
            IN_VALID = 1'b1;
            IN_START = start;
            IN_SRC   = q_src[i];
            IN_DST   = q_dst[i];
            IN_W     = q_w[i];
            @(posedge CLK); #1;
        end
        IN_VALID = 1'b0;
        q_src.delete();
        q_dst.delete();
        q_w.delete();
    endtask

    task automatic collect(input string name, input int exp_lat, input int exp_ovf);
        int lat;
        lat = 0;
        while (!OUT_VALID && lat < 2000) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " ovf"}, {31'd0, OVF}, exp_ovf);
        for (int n = 0; n < NODES; n++) begin
            chk($sformatf("%s valid%0d", name, n), {31'd0, OUT_VALID}, 1);
            chk($sformatf("%s node%0d", name, n), {29'd0, OUT_NODE}, n);
            chk($sformatf("%s dist%0d", name, n), {22'd0, OUT_DIST}, exp_d[n]);
            chk($sformatf("%s reach%0d", name, n), {31'd0, OUT_REACH}, (exp_d[n] != INF) ? 1 : 0);
            @(posedge CLK); #1;
        end
        chk({name, " valid_end"}, {31'd0, OUT_VALID}, 0);
        chk({name, " busy_end"}, {31'd0, BUSY}, 0);
        chk({name, " dist_end"}, {22'd0, OUT_DIST}, 0);
    endtask

    task automatic check_zero_outputs(input string name);
        chk({name, " busy"}, {31'd0, BUSY}, 0);
        chk({name, " ovf"}, {31'd0, OVF}, 0);
        chk({name, " valid"}, {31'd0, OUT_VALID}, 0);
        chk({name, " node"}, {29'd0, OUT_NODE}, 0);
        chk({name, " dist"}, {22'd0, OUT_DIST}, 0);
        chk({name, " reach"}, {31'd0, OUT_REACH}, 0);
    endtask

    task automatic load_basic();
        add(0, 1, 3); add(1, 2, 4); add(0, 2, 10); add(2, 3, 1);
        exp_d = '{0, 3, 7, 8, INF, INF, INF, INF};
    endtask

    initial begin
        RESET = 1'b1; IN_VALID = 1'b0; IN_START = '0; IN_SRC = '0; IN_DST = '0; IN_W = '0;
        #1;
        check_zero_outputs("reset");
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(posedge CLK); #1;

        // Four edges, two passes over four edges.
        load_basic();
        send(3'd0);
        chk("basic busy", {31'd0, BUSY}, 1);
        collect("basic", 9, 0);

        // Reverse-ordered chain: one new node settles per pass, capped at NODES-1 passes.
        for (int k = 6; k >= 0; k--) add(3'(k), 3'(k + 1), 1);
        for (int k = 0; k < NODES; k++) exp_d[k] = k;
        send(3'd0);
        collect("chain", 7 * 7 + 1, 0);

        // Seventeenth edge would reach node 2 but must be dropped.
        add(0, 1, 1);
        for (int k = 0; k < 15; k++) add(1, 1, 1);
        add(1, 2, 1);
        exp_d = '{0, 1, INF, INF, INF, INF, INF, INF};
        send(3'd0);
        collect("overflow", 2 * 16 + 1, 1);

        // Heavy forward chain saturates at 2^DW-2 = 1022.
        for (int k = 0; k < 7; k++) add(3'(k), 3'(k + 1), 8'd255);
        exp_d = '{0, 255, 510, 765, 1020, 1022, 1022, 1022};
        send(3'd0);
        collect("saturate", 2 * 7 + 1, 0);

        // Self-loop only; start node is the sole reachable node.
        add(3, 3, 5);
        exp_d = '{INF, INF, INF, 0, INF, INF, INF, INF};
        send(3'd3);
        collect("selfloop", 2, 0);

        // Reset in the middle of relaxation, then a fresh problem.
        for (int k = 6; k >= 0; k--) add(3'(k), 3'(k + 1), 1);
        send(3'd0);
        repeat (10) @(posedge CLK);
        #1;
        chk("midrst busy_before", {31'd0, BUSY}, 1);
        RESET = 1'b1;
        #1;
        check_zero_outputs("midrst");
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(posedge CLK); #1;
        load_basic();
        send(3'd0);
        collect("after_rst", 9, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
